// File: rtl/demux_frame_sequencer.sv
// demux_frame_sequencer
// Feeds the 1-to-4 behavioural demux datapath. It accepts channel-tagged words
// over a valid/ready handshake and serialises each word LSB-first onto `d`.
// While a frame is shifted out, `s` holds the tagged channel. A pending register
// sits in front of the active shift register, so frames can run back-to-back,
// and an optional idle gap can follow each frame.
module demux_frame_sequencer #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_ch,
    output logic              d,
    output logic [1:0]        s,
    output logic              busy,
    output logic              frame_done
);

    // Bit counter width; a one-bit frame still needs a one-bit counter.
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    // Gap counter compares against GAP_CYCLES-1; unused when GAP_CYCLES is 0.
    localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] pend_data;
    logic [1:0]        pend_ch;
    logic              pend_full;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [3:0]        gap_cnt;
    logic              accept;
    logic              load;
    logic              frame_end;

    // in_ready depends only on the pending flag, never on in_valid.
    assign in_ready = !pend_full;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    // Decide when the shift register takes the pending word.
    always_comb begin
        frame_end = (state == SHIFT) && (cnt == LAST_BIT);
        cnt_nxt   = cnt + 1'b1;
        load      = 1'b0;
        case (state)
            IDLE:    load = pend_full;
            SHIFT:   load = frame_end && (GAP_CYCLES == 0) && pend_full;
            GAP:     load = (gap_cnt == GAP_LAST) && pend_full;
            default: load = 1'b0;
        endcase
    end

    // Pending-buffer occupancy: fill on a transfer, empty when the frame loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full <= 1'b0;
        end else if (accept) begin
            pend_full <= 1'b1;
        end else if (load) begin
            pend_full <= 1'b0;
        end
    end

    // Pending word payload, captured at the transfer edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_data <= in_data;
            pend_ch   <= in_ch;
        end
    end

    // Active shift register; bit 0 goes straight to `d` at load, the rest follow.
    always_ff @(posedge clk) begin
        if (load) begin
            shreg <= pend_data >> 1;
        end else if (state == SHIFT) begin
            shreg <= shreg >> 1;
        end
    end

    // Frame FSM with registered d, s and frame_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            d          <= 1'b0;
            s          <= 2'b00;
            frame_done <= 1'b0;
            cnt        <= '0;
            gap_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;
            if (load) begin
                // s changes only here, so the channel is stable for the whole frame.
                s          <= pend_ch;
                d          <= pend_data[0];
                cnt        <= '0;
                gap_cnt    <= '0;
                frame_done <= (DATA_W == 1);
                state      <= SHIFT;
            end else begin
                case (state)
                    IDLE: begin
                        d <= 1'b0;
                    end
                    SHIFT: begin
                        if (frame_end) begin
                            d       <= 1'b0;
                            gap_cnt <= '0;
                            state   <= (GAP_CYCLES > 0) ? GAP : IDLE;
                        end else begin
                            d          <= shreg[0];
                            cnt        <= cnt_nxt;
                            frame_done <= (cnt_nxt == LAST_BIT);
                        end
                    end
                    GAP: begin
                        d <= 1'b0;
                        if (gap_cnt == GAP_LAST) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: begin
                        d     <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_demux_frame_sequencer.sv
// Directed bench for demux_frame_sequencer. It uses three instances that differ
// only in gap length: index 0 has GAP_CYCLES=1, index 1 has 0 and index 2 has 3.
module tb_demux_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv   [3];
    logic [7:0] idat [3];
    logic [1:0] ich  [3];
    logic       rdy  [3];
    logic       dq   [3];
    logic [1:0] sq   [3];
    logic       bsy  [3];
    logic       fd   [3];

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    demux_frame_sequencer #(.DATA_W(8), .GAP_CYCLES(1)) u_gap1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]),
        .in_data(idat[0]), .in_ch(ich[0]), .d(dq[0]), .s(sq[0]),
        .busy(bsy[0]), .frame_done(fd[0])
    );

    demux_frame_sequencer #(.DATA_W(8), .GAP_CYCLES(0)) u_gap0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]),
        .in_data(idat[1]), .in_ch(ich[1]), .d(dq[1]), .s(sq[1]),
        .busy(bsy[1]), .frame_done(fd[1])
    );

    demux_frame_sequencer #(.DATA_W(8), .GAP_CYCLES(3)) u_gap3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy[2]),
        .in_data(idat[2]), .in_ch(ich[2]), .d(dq[2]), .s(sq[2]),
        .busy(bsy[2]), .frame_done(fd[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the 8 bit cycles of one frame; the frame's first bit must already be on d.
    task automatic expect_bits(input int k, input logic [7:0] w, input logic [1:0] ch,
                               input string tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_d%0d", tag, i), 32'(dq[k]), 32'(w[i]));
            chk($sformatf("%s_s%0d", tag, i), 32'(sq[k]), 32'(ch));
            chk($sformatf("%s_fd%0d", tag, i), 32'(fd[k]), 32'(i == 7));
            chk($sformatf("%s_busy%0d", tag, i), 32'(bsy[k]), 32'd1);
            tick();
        end
    endtask

    // A producer offers n words continuously while a consumer checks every output cycle.
    task automatic stream(input int k, input int n, input logic [31:0] words,
                          input logic [7:0] chs, input int gap, input string tag);
        int stall3;
        stall3 = 0;
        fork
            begin
                for (int j = 0; j < n; j++) begin
                    int t;
                    t = 0;
                    iv[k]   = 1'b1;
                    idat[k] = words[8*j +: 8];
                    ich[k]  = chs[2*j +: 2];
                    while (!rdy[k] && t < 100) begin
                        if (j == 2) stall3++;
                        tick();
                        t++;
                    end
                    if (t >= 100) chk($sformatf("%s_accept_timeout%0d", tag, j), 32'd0, 32'd1);
                    tick();
                end
                iv[k] = 1'b0;
            end
            begin
                int t;
                t = 0;
                while (!bsy[k] && t < 20) begin
                    tick();
                    t++;
                end
                chk({tag, "_start"}, 32'(bsy[k]), 32'd1);
                for (int j = 0; j < n; j++) begin
                    expect_bits(k, words[8*j +: 8], chs[2*j +: 2], $sformatf("%s_f%0d", tag, j));
                    for (int g = 0; g < gap; g++) begin
                        chk($sformatf("%s_gap_d%0d_%0d", tag, j, g), 32'(dq[k]), 32'd0);
                        chk($sformatf("%s_gap_s%0d_%0d", tag, j, g), 32'(sq[k]), 32'(chs[2*j +: 2]));
                        chk($sformatf("%s_gap_busy%0d_%0d", tag, j, g), 32'(bsy[k]), 32'd1);
                        tick();
                    end
                end
                chk({tag, "_end_busy"}, 32'(bsy[k]), 32'd0);
                chk({tag, "_end_d"}, 32'(dq[k]), 32'd0);
                chk({tag, "_end_s"}, 32'(sq[k]), 32'(chs[2*(n-1) +: 2]));
            end
        join
        if (n >= 3) chk({tag, "_third_stalled"}, 32'(stall3 > 0), 32'd1);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            iv[k]   = 1'b0;
            idat[k] = 8'h00;
            ich[k]  = 2'd0;
        end
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_d", 32'(dq[0]), 32'd0);
        chk("rst_s", 32'(sq[0]), 32'd0);
        chk("rst_busy", 32'(bsy[0]), 32'd0);
        chk("rst_fd", 32'(fd[0]), 32'd0);
        chk("rst_ready0", 32'(rdy[0]), 32'd1);
        chk("rst_ready1", 32'(rdy[1]), 32'd1);
        chk("rst_ready2", 32'(rdy[2]), 32'd1);

        // Single word A5 on channel 2, with the one-cycle load latency checked explicitly
        iv[0] = 1'b1; idat[0] = 8'hA5; ich[0] = 2'd2;
        tick();
        chk("t1_ready_after_accept", 32'(rdy[0]), 32'd0);
        chk("t1_busy_before_load", 32'(bsy[0]), 32'd0);
        chk("t1_d_before_load", 32'(dq[0]), 32'd0);
        iv[0] = 1'b0; idat[0] = 8'h00; ich[0] = 2'd0;
        tick();
        expect_bits(0, 8'hA5, 2'd2, "t1");
        chk("t1_gap_d", 32'(dq[0]), 32'd0);
        chk("t1_gap_busy", 32'(bsy[0]), 32'd1);
        chk("t1_gap_s", 32'(sq[0]), 32'd2);
        tick();
        chk("t1_idle_busy", 32'(bsy[0]), 32'd0);
        chk("t1_idle_d", 32'(dq[0]), 32'd0);
        chk("t1_idle_s", 32'(sq[0]), 32'd2);
        chk("t1_idle_ready", 32'(rdy[0]), 32'd1);

        // Back-to-back 0F ch1, F0 ch3 with no gap
        stream(1, 2, 32'h0000_F00F, 8'b0000_1101, 0, "b2b");

        // Three words offered continuously; the third must stall
        stream(0, 3, 32'h0033_2211, 8'b0010_0100, 1, "three");

        // Three-cycle gap between two frames, s held at the first channel
        stream(2, 2, 32'h0000_C35A, 8'b0000_0110, 3, "gap3");

        // All ones then all zeros on channel 0
        stream(0, 2, 32'h0000_00FF, 8'h00, 1, "ffzz");

        // Reset mid-frame with pending full
        iv[0] = 1'b1; idat[0] = 8'h3C; ich[0] = 2'd3;
        tick();
        idat[0] = 8'h55; ich[0] = 2'd1;
        tick();
        tick();
        iv[0] = 1'b0;
        chk("mr_pending_full", 32'(rdy[0]), 32'd0);
        tick();
        tick();
        chk("mr_bit4_busy", 32'(bsy[0]), 32'd1);
        chk("mr_bit4_d", 32'(dq[0]), 32'd1);
        chk("mr_bit4_s", 32'(sq[0]), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_d", 32'(dq[0]), 32'd0);
        chk("mr_s", 32'(sq[0]), 32'd0);
        chk("mr_busy", 32'(bsy[0]), 32'd0);
        chk("mr_ready", 32'(rdy[0]), 32'd1);
        chk("mr_fd", 32'(fd[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("mr_after_busy%0d", i), 32'(bsy[0]), 32'd0);
            chk($sformatf("mr_after_d%0d", i), 32'(dq[0]), 32'd0);
        end
        chk("mr_after_ready", 32'(rdy[0]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
